// File: rtl/word_serializer_pkg.sv
// Package for the word serializer: word/select widths and FSM state codes.
package word_serializer_pkg;

  localparam int WIDTH = 32;  // word width, fixed to match the 32:1 mux
  localparam int SEL_W = 5;   // select width, log2(WIDTH)

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/word_serializer_mux.sv
// 32:1 bit mux used by the word serializer.
// Ports:
//   x  in  WIDTH  word whose bits are selected
//   s  in  SEL_W  select index
//   y  out 1      x[s]
module word_serializer_mux
  import word_serializer_pkg::*;
(
  input  logic [WIDTH-1:0] x,
  input  logic [SEL_W-1:0] s,
  output logic             y
);

  assign y = x[s];

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial stage: captures a 32-bit word on a load handshake and
// emits it one bit per accepted beat on a valid/ready stream, LAST on the
// final bit. Bit order is X[0]..X[31], or X[31]..X[0] when MSB_FIRST=1.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. valid never depends on ready; once bit_valid is raised, bit_out,
// last and s hold until the bit is accepted or the word is aborted.
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   load_valid  in   1      a word is offered on d
//   load_ready  out  1      block can accept a word (state is IDLE)
//   d           in   32     word to serialize
//   abort       in   1      synchronous cancel of the word in flight
//   bit_valid   out  1      bit_out holds a valid bit
//   bit_ready   in   1      consumer accepts the bit
//   bit_out     out  1      current bit X[s]; 0 when bit_valid=0
//   last        out  1      high with the final bit of the word
//   s           out  5      current mux select
//   dbg_state   out  1      FSM state (0=IDLE, 1=SHIFT)
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             abort,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic             last,
  output logic [SEL_W-1:0] s,
  output logic             dbg_state
);

  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_W'(WIDTH - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] x;
  logic [SEL_W-1:0] s_next;
  logic             mux_y;

  // Only used when s is not the end index, so it never wraps.
  assign s_next = MSB_FIRST ? (s - SEL_W'(1)) : (s + SEL_W'(1));

  // bit_valid and last are registered alongside the state so they always
  // agree with it: bit_valid == SHIFT, last == SHIFT && s == end index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      x         <= '0;
      s         <= '0;
      bit_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort is meaningless here and must not block the load
          if (load_valid) begin
            x         <= d;
            s         <= SEL_FIRST;
            state     <= ST_SHIFT;
            bit_valid <= 1'b1;
            last      <= 1'b0;
          end
        end
        ST_SHIFT: begin
          // abort wins over bit_ready, including on the final bit
          if (abort) begin
            state     <= ST_IDLE;
            bit_valid <= 1'b0;
            last      <= 1'b0;
          end else if (bit_ready) begin
            if (s == SEL_END) begin
              state     <= ST_IDLE;
              bit_valid <= 1'b0;
              last      <= 1'b0;
            end else begin
              s    <= s_next;
              last <= (s_next == SEL_END);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          bit_valid <= 1'b0;
          last      <= 1'b0;
        end
      endcase
    end
  end

  word_serializer_mux u_mux (
    .x (x),
    .s (s),
    .y (mux_y)
  );

  assign load_ready = (state == ST_IDLE);
  assign bit_out    = mux_y & bit_valid;
  assign dbg_state  = (state == ST_SHIFT);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: one LSB-first and one MSB-first instance share
// the same stimulus. The model holds, per instance, the queue of bits still
// owed for the current word.
module tb_word_serializer;

  logic        clk;
  logic        rst_n;
  logic        load_valid;
  logic [31:0] d;
  logic        abort;
  logic        bit_ready;

  logic       l_load_ready, l_bit_valid, l_bit_out, l_last, l_dbg_state;
  logic [4:0] l_s;
  logic       m_load_ready, m_bit_valid, m_bit_out, m_last, m_dbg_state;
  logic [4:0] m_s;

  int checks   = 0;
  int failures = 0;

  word_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(l_load_ready),
    .d(d), .abort(abort), .bit_valid(l_bit_valid), .bit_ready(bit_ready),
    .bit_out(l_bit_out), .last(l_last), .s(l_s), .dbg_state(l_dbg_state)
  );

  word_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(m_load_ready),
    .d(d), .abort(abort), .bit_valid(m_bit_valid), .bit_ready(bit_ready),
    .bit_out(m_bit_out), .last(m_last), .s(m_s), .dbg_state(m_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [0:0] exp_lsb_q[$];
  logic [0:0] exp_msb_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_lsb_q.delete();
      exp_msb_q.delete();
    end else if (exp_lsb_q.size() != 0) begin
      if (abort) begin
        exp_lsb_q.delete();
        exp_msb_q.delete();
      end else if (bit_ready) begin
        void'(exp_lsb_q.pop_front());
        void'(exp_msb_q.pop_front());
      end
    end else if (load_valid) begin
      for (int i = 0; i < 32; i++) begin
        exp_lsb_q.push_back(d[i]);
        exp_msb_q.push_back(d[31-i]);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int  n;
    logic busy;
    n    = exp_lsb_q.size();
    busy = (n != 0);
    chk("lsb_load_ready", l_load_ready, !busy);
    chk("msb_load_ready", m_load_ready, !busy);
    chk("lsb_bit_valid", l_bit_valid, busy);
    chk("msb_bit_valid", m_bit_valid, busy);
    chk("lsb_state", l_dbg_state, busy);
    chk("msb_state", m_dbg_state, busy);
    chk("lsb_bit_out", l_bit_out, busy ? exp_lsb_q[0] : 1'b0);
    chk("msb_bit_out", m_bit_out, busy ? exp_msb_q[0] : 1'b0);
    chk("lsb_last", l_last, n == 1);
    chk("msb_last", m_last, n == 1);
    if (busy) begin
      chk("lsb_s", l_s, 32 - n);
      chk("msb_s", m_s, n - 1);
    end
    if (!rst_n) begin
      chk("lsb_s_reset", l_s, 0);
      chk("msb_s_reset", m_s, 0);
    end
  end

  // ---------------- capture of accepted bits ----------------
  logic cap_lsb[$];
  logic cap_msb[$];
  int   valid_cycles, last_cnt, last_idx, last_cyc;

  always @(negedge clk) begin
    if (rst_n && l_bit_valid) begin
      valid_cycles++;
      if (bit_ready && !abort) begin
        cap_lsb.push_back(l_bit_out);
        cap_msb.push_back(m_bit_out);
        if (l_last) begin
          last_cnt++;
          last_idx = cap_lsb.size() - 1;
          last_cyc = valid_cycles;
        end
      end
    end
  end

  task automatic clear_cap();
    cap_lsb.delete();
    cap_msb.delete();
    valid_cycles = 0;
    last_cnt     = 0;
    last_idx     = -1;
    last_cyc     = -1;
  endtask

  task automatic check_word(input string name, input logic [31:0] exp_l,
                            input logic [31:0] exp_m);
    logic [31:0] wl, wm;
    wl = '0;
    wm = '0;
    for (int i = 0; i < 32 && i < cap_lsb.size(); i++) begin
      wl[i] = cap_lsb[i];
      wm[i] = cap_msb[i];
    end
    chk({name, "_count"}, cap_lsb.size(), 32);
    chk({name, "_lsb_word"}, wl, exp_l);
    chk({name, "_msb_word"}, wm, exp_m);
    chk({name, "_last_cnt"}, last_cnt, 1);
    chk({name, "_last_idx"}, last_idx, 31);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w);
    load_valid = 1'b1;
    d          = w;
    tick();
    load_valid = 1'b0;
    d          = $urandom;
  endtask

  task automatic run_bits(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      bit_ready = toggle ? i[0] : 1'b1;
      tick();
    end
    bit_ready = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!l_load_ready && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", l_load_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    load_valid = 1'b0;
    d          = '0;
    abort      = 1'b0;
    bit_ready  = 1'b1;
    clear_cap();
    tick();
    chk("reset_load_ready", l_load_ready, 1'b1);
    chk("reset_bit_valid", l_bit_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset in the middle of a word, at bit 7
    load_word(32'h12345678);
    run_bits(7, 1'b0);
    chk("pre_reset_s", l_s, 7);
    rst_n = 1'b0;
    #1;
    chk("midreset_bit_valid", l_bit_valid, 1'b0);
    chk("midreset_s", l_s, 0);
    chk("midreset_load_ready", l_load_ready, 1'b1);
    chk("midreset_bit_out", l_bit_out, 1'b0);
    chk("midreset_msb_s", m_s, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_cap();
    load_word(32'h00000003);
    run_bits(32, 1'b0);
    check_word("after_reset", 32'h00000003, 32'hC0000000);

    // alternating pattern, full rate
    wait_idle(40);
    clear_cap();
    load_word(32'hAAAAAAAA);
    run_bits(32, 1'b0);
    chk("aa_idle_after_32", l_load_ready, 1'b1);
    chk("aa_valid_cycles", valid_cycles, 32);
    check_word("aa", 32'hAAAAAAAA, 32'h55555555);

    // end bits set, middle clear
    wait_idle(40);
    clear_cap();
    load_word(32'h80000001);
    run_bits(32, 1'b0);
    chk("ends_idle_after_32", m_load_ready, 1'b1);
    check_word("ends", 32'h80000001, 32'h80000001);

    // backpressure every other cycle
    wait_idle(40);
    clear_cap();
    load_word(32'hAAAAAAAA);
    run_bits(64, 1'b1);
    chk("bp_cycles_to_last", last_cyc, 64);
    chk("bp_idle", l_load_ready, 1'b1);
    check_word("bp", 32'hAAAAAAAA, 32'h55555555);

    // load pulse while shifting is ignored
    wait_idle(80);
    clear_cap();
    load_word(32'h0000FFFF);
    run_bits(5, 1'b0);
    load_valid = 1'b1;
    d          = 32'hFFFFFFFF;
    tick();
    load_valid = 1'b0;
    run_bits(26, 1'b0);
    chk("ignore_idle", l_load_ready, 1'b1);
    check_word("ignore", 32'h0000FFFF, 32'hFFFF0000);

    // abort at s=10, then a load coinciding with abort in IDLE
    wait_idle(40);
    clear_cap();
    load_word(32'hFFFFFFFF);
    run_bits(10, 1'b0);
    chk("abort_s", l_s, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", l_load_ready, 1'b1);
    chk("abort_bits", cap_lsb.size(), 10);
    chk("abort_no_last", last_cnt, 0);
    clear_cap();
    abort = 1'b1;
    load_word(32'h0000000F);
    abort = 1'b0;
    run_bits(32, 1'b0);
    check_word("post_abort", 32'h0000000F, 32'hF0000000);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
